ttl_jk_sequencer: RTL and testbench
===================================

# ttl_jk_sequencer

Command-driven controller for a bank of negative-edge-triggered J-K flip-flops with preset and clear (dual J-K 7400-family part, `BLOCKS` wide). It accepts one command at a time over a valid/ready handshake and drives the bank's J, K and Preset_bar lines to perform it. Supported commands are load, masked toggle, masked preset and N-step synchronous count. It sits between glue logic and the flip-flop bank, and reads the bank's Q back for counting.

## Interface
- `BLOCKS`, 4: number of flip-flops in the controlled bank.
- `DELAY_RISE`, 0: rise delay on all outputs.
- `DELAY_FALL`, 0: fall delay on all outputs.

- `Clk`  in  1: clock. The controller registers on the rising edge. The bank shares this clock and samples on the falling edge.
- `Clear_bar`  in  1: reset, asynchronous, active-low. Also tied to the bank's Clear_bar.
- `Cmd_valid`  in  1: command present.
- `Cmd_ready`  out  1: controller idle; a command is accepted on a rising edge where valid and ready are both high.
- `Op`  in  3: opcode.
  - 000 NOP
  - 001 LOAD
  - 010 TOGGLE
  - 011 PRESET
  - 100 COUNT
  - 101–111 treated as NOP
- `Arg`  in  BLOCKS: operand. Data for LOAD, mask for TOGGLE/PRESET, step count for COUNT.
- `Q_in`  in  BLOCKS: Q fed back from the bank.
- `J`, `K`  out  BLOCKS: to the bank's J/K inputs.
- `Preset_bar`  out  BLOCKS: to the bank's Preset_bar inputs.
- `Done`  out  1: single-cycle completion pulse.

## Operation
- **States:** IDLE, DRIVE, PRE_ARM, PRE_LOW, PRE_REL, COUNT.
- **Reset values (Clear_bar low):**
  - J = K = 0; Preset_bar = all ones.
  - Cmd_ready = 1; Done = 0; state IDLE; step counter = 0.
- **IDLE:**
  - J = K = 0 and Preset_bar = all ones, so the bank holds.
  - Cmd_ready = 1.
  - On accept, Cmd_ready drops and Op/Arg are captured.
- **NOP or invalid Op:** DRIVE one cycle with J = K = 0.
- **LOAD:** DRIVE one cycle with J = Arg and K = ~Arg.
- **TOGGLE:** DRIVE one cycle with J = K = Arg.
- **PRESET:** three drive cycles, J = K = 0 throughout.
  - PRE_ARM: Preset_bar = all ones. This guarantees the bank sees a high level before the low.
  - PRE_LOW: Preset_bar = ~Arg.
  - PRE_REL: Preset_bar = all ones.
  - Reason: the bank's preset acts on a sampled high-to-low transition at a falling Clk edge. Masked bits go to 1; unmasked bits hold.
- **COUNT, Arg = N:**
  - N = 0 behaves as NOP.
  - Otherwise N drive cycles. Each cycle registers J[i] = K[i] = AND of Q_in[i-1:0], with bit 0 always 1.
  - Step counter loads N on accept and decrements each drive cycle. The last step is the one driven while the counter is at 1.
  - All-ones wraps to zero naturally.
- **After the last drive cycle:**
  - Return to IDLE with J = K = 0 and Preset_bar = all ones.
  - Done = 1 for exactly that cycle; Cmd_ready = 1.
- Command inputs are ignored while Cmd_ready = 0.

## Timing
- All outputs are registered on the rising Clk edge. The bank consumes them on the following falling edge, giving a half-cycle setup.
- Q_in is settled by the next rising edge.
- **COUNT sustains one step per cycle:** J/K registered at edge k use the Q produced by the falling edge of step k-1.
- **Latency, command accepted at rising edge t:**
  - NOP / LOAD / TOGGLE / COUNT with N = 0: drive t..t+1. Done and Cmd_ready are high from edge t+1.
  - PRESET: drive t..t+3. Done from t+3.
  - COUNT N > 0: drive t..t+N. Done from t+N.
- Earliest next accept is the edge after Done rises (t+2 for LOAD).
- Done is high for exactly one cycle per command. It is never asserted for a command aborted by reset.
- **Reset mid-operation:**
  - Clear_bar low immediately forces the reset values and aborts the command with no Done.
  - The bank clears to Q = 0 in parallel.
  - After release, the controller is in IDLE.
- Cmd_valid held high continuously is accepted once per command, each time Cmd_ready is high at a rising edge.

## Test plan
- **Reset:** Clear_bar low mid-cycle → outputs go immediately to J = K = 0, Preset_bar = 4'hF, Cmd_ready = 1, Done = 0; bank Q = 0.
- **LOAD:** LOAD Arg = 4'hA accepted at t → J = 4'hA, K = 4'h5 for one cycle. Bank Q = 4'hA after the next falling edge. Done is a single pulse from t+1.
- **PRESET:** from Q = 4'hA, PRESET Arg = 4'h3 → Preset_bar sequence 4'hF, 4'hC, 4'hF on consecutive cycles, with J = K = 0. Q = 4'hB. Done from t+3.
- **COUNT with wrap:** from Q = 4'hE, COUNT Arg = 5 → Q steps F, 0, 1, 2, 3 on consecutive falling edges. Done from t+5. A following COUNT Arg = 0 gives Done at its t+1 and Q stays 3.
- **TOGGLE and back-to-back:** from Q = 4'h3, TOGGLE Arg = 4'h6 with Cmd_valid held high, then LOAD 4'h0 → Q = 4'h5, then 4'h0. Each command produces exactly one Done. The second accept occurs at the edge after the first Done rises.
- **Reset mid-COUNT:** Clear_bar asserted after 2 of 8 steps → J = K = 0 immediately; Q = 0; no Done; Cmd_ready = 1 after release; the next LOAD operates normally.

Source files
------------

// File: rtl/ttl_jk_sequencer.sv
// Command sequencer for a bank of negedge J-K flip-flops with preset/clear.
// Accepts one command per valid/ready handshake and drives the bank's J, K and
// Preset_bar lines; all outputs are registered on the rising edge of Clk.

package ttl_jk_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_PRE_ARM, S_PRE_LOW, S_PRE_REL, S_COUNT
  } state_t;

  // What a single flip-flop's drive lines should carry next cycle
  typedef enum logic [2:0] {
    L_HOLD, L_LOAD, L_TOGGLE, L_COUNT, L_PRESET
  } lane_sel_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_TOGGLE = 3'd2;
  localparam logic [2:0] OP_PRESET = 3'd3;
  localparam logic [2:0] OP_COUNT  = 3'd4;
endpackage

// Per-flip-flop drive decode: d is data/mask bit, carry is the count enable.
module ttl_jk_lane
  import ttl_jk_sequencer_pkg::*;
(
  input  lane_sel_t sel,
  input  logic      d,
  input  logic      carry,
  output logic      j,
  output logic      k,
  output logic      pre_n
);
  // Idle drive is hold (J=K=0) with preset released
  always_comb begin
    j     = 1'b0;
    k     = 1'b0;
    pre_n = 1'b1;
    unique case (sel)
      L_LOAD:   begin j = d;     k = ~d;    end
      L_TOGGLE: begin j = d;     k = d;     end
      L_COUNT:  begin j = carry; k = carry; end
      L_PRESET: pre_n = ~d;
      default:  ;
    endcase
  end
endmodule

module ttl_jk_sequencer
  import ttl_jk_sequencer_pkg::*;
#(
  parameter int BLOCKS     = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic              Clk,
  input  logic              Clear_bar,
  input  logic              Cmd_valid,
  output logic              Cmd_ready,
  input  logic [2:0]        Op,
  input  logic [BLOCKS-1:0] Arg,
  input  logic [BLOCKS-1:0] Q_in,
  output logic [BLOCKS-1:0] J,
  output logic [BLOCKS-1:0] K,
  output logic [BLOCKS-1:0] Preset_bar,
  output logic              Done
);
  // Delays exist for interface compatibility with the TTL timing model; the
  // registered outputs here switch with zero delay, so only sanity-check them.
  if (BLOCKS < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_param
    $error("ttl_jk_sequencer: invalid parameters");
  end

  typedef struct packed {
    logic [2:0]        op;
    logic [BLOCKS-1:0] arg;
  } cmd_t;

  cmd_t              cmd_in, cmd_q;
  state_t            state, nstate;
  logic [BLOCKS-1:0] cnt, cnt_d;
  lane_sel_t         sel;
  logic [BLOCKS-1:0] lane_d, carry, j_d, k_d, pre_d;
  logic              done_d, rdy_d, accept;

  assign cmd_in = '{op: Op, arg: Arg};
  assign accept = Cmd_valid & Cmd_ready;

  // Synchronous-counter enables: bit i toggles when all lower Q bits are 1
  for (genvar i = 0; i < BLOCKS; i++) begin : g_carry
    localparam logic [BLOCKS-1:0] LOW = {BLOCKS{1'b1}} >> (BLOCKS - i);
    assign carry[i] = &(Q_in | ~LOW);
  end

  // One drive decoder per flip-flop
  for (genvar i = 0; i < BLOCKS; i++) begin : g_lane
    ttl_jk_lane u_lane (
      .sel   (sel),
      .d     (lane_d[i]),
      .carry (carry[i]),
      .j     (j_d[i]),
      .k     (k_d[i]),
      .pre_n (pre_d[i])
    );
  end

  // State, step counter and captured command
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state <= S_IDLE;
      cnt   <= '0;
      cmd_q <= '0;
    end else begin
      state <= nstate;
      cnt   <= cnt_d;
      if (accept) cmd_q <= cmd_in;
    end
  end

  // Next state; counter loads N on accept and the step at cnt==1 is the last
  always_comb begin
    nstate = state;
    cnt_d  = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (Op)
            OP_PRESET: nstate = S_PRE_ARM;
            OP_COUNT: begin
              if (Arg != '0) begin
                nstate = S_COUNT;
                cnt_d  = Arg;
              end else begin
                nstate = S_DRIVE;
              end
            end
            default:   nstate = S_DRIVE;
          endcase
        end
      end
      S_DRIVE:   nstate = S_IDLE;
      S_PRE_ARM: nstate = S_PRE_LOW;
      S_PRE_LOW: nstate = S_PRE_REL;
      S_PRE_REL: nstate = S_IDLE;
      S_COUNT: begin
        if (cnt == BLOCKS'(1)) begin
          nstate = S_IDLE;
          cnt_d  = '0;
        end else begin
          cnt_d  = cnt - BLOCKS'(1);
        end
      end
      default:   nstate = S_IDLE;
    endcase
  end

  // Output decode for the cycle being entered; DRIVE is only entered on
  // accept, so it takes Op/Arg straight from the inputs
  always_comb begin
    sel    = L_HOLD;
    lane_d = cmd_q.arg;
    done_d = 1'b0;
    rdy_d  = 1'b0;
    case (nstate)
      S_IDLE: begin
        rdy_d  = 1'b1;
        done_d = (state != S_IDLE);
      end
      S_DRIVE: begin
        lane_d = cmd_in.arg;
        case (cmd_in.op)
          OP_LOAD:   sel = L_LOAD;
          OP_TOGGLE: sel = L_TOGGLE;
          default:   sel = L_HOLD;
        endcase
      end
      S_PRE_LOW: sel = L_PRESET;
      S_COUNT:   sel = L_COUNT;
      default:   sel = L_HOLD;
    endcase
  end

  // Registered bank drive and handshake outputs
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      J          <= '0;
      K          <= '0;
      Preset_bar <= '1;
      Cmd_ready  <= 1'b1;
      Done       <= 1'b0;
    end else begin
      J          <= j_d;
      K          <= k_d;
      Preset_bar <= pre_d;
      Cmd_ready  <= rdy_d;
      Done       <= done_d;
    end
  end
endmodule

// File: tb/tb_ttl_jk_sequencer.sv
// Bench for ttl_jk_sequencer: a behavioural J-K bank closes the Q loop, the
// stimulus pushes expected (Q, Done cycle) pairs and a monitor checks each Done.
module tb_ttl_jk_sequencer;
  logic       Clk, Clear_bar, Cmd_valid, Cmd_ready, Done;
  logic [2:0] Op;
  logic [3:0] Arg, J, K, Preset_bar, q_bank, pre_prev;

  int         cyc = 0;
  int         n_pass = 0, n_total = 0;
  logic [3:0] exp_q[$];
  int         exp_c[$];

  ttl_jk_sequencer #(.BLOCKS(4), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
    .Clk        (Clk),
    .Clear_bar  (Clear_bar),
    .Cmd_valid  (Cmd_valid),
    .Cmd_ready  (Cmd_ready),
    .Op         (Op),
    .Arg        (Arg),
    .Q_in       (q_bank),
    .J          (J),
    .K          (K),
    .Preset_bar (Preset_bar),
    .Done       (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Flip-flop bank: falling-edge J-K, preset on sampled high-to-low, async clear
  always @(negedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      q_bank   <= 4'h0;
      pre_prev <= 4'hF;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pre_prev[i] && !Preset_bar[i]) q_bank[i] <= 1'b1;
        else case ({J[i], K[i]})
          2'b10:   q_bank[i] <= 1'b1;
          2'b01:   q_bank[i] <= 1'b0;
          2'b11:   q_bank[i] <= ~q_bank[i];
          default: ;
        endcase
      end
      pre_prev <= Preset_bar;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every Done must match the oldest outstanding expectation
  always @(posedge Clk) begin
    #1;
    if (Done) begin
      if (exp_c.size() == 0) check("spurious_done", 1, 0);
      else begin
        check("done_cycle", cyc, exp_c.pop_front());
        check("done_q", q_bank, exp_q.pop_front());
      end
    end else if (exp_c.size() > 0 && cyc > exp_c[0]) begin
      check("done_missing", 0, 1);
      void'(exp_c.pop_front());
      void'(exp_q.pop_front());
    end
  end

  // Issue one command; returns #1 after the accepting edge
  task automatic send(input logic [2:0] op, input logic [3:0] arg, input logic [3:0] q,
                      input int lat, input bit track, input bit hold);
    int g = 0;
    while (!Cmd_ready && g < 50) begin @(posedge Clk); #1; g++; end
    if (g >= 50) check("ready_timeout", 0, 1);
    Op = op; Arg = arg; Cmd_valid = 1'b1;
    @(posedge Clk); #1;
    if (track) begin exp_q.push_back(q); exp_c.push_back(cyc + lat); end
    if (!hold) Cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_c.size() > 0 && g < 50) begin @(posedge Clk); #1; g++; end
    check("drain_empty", exp_c.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] cseq[5];
    int t0;
    cseq = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h3};
    Clear_bar = 1'b1; Cmd_valid = 1'b0; Op = 3'd0; Arg = 4'h0;

    // Reset asserted mid-cycle takes effect immediately
    repeat (2) @(posedge Clk);
    #3 Clear_bar = 1'b0;
    #1;
    check("rst_j", J, 4'h0);
    check("rst_k", K, 4'h0);
    check("rst_pre", Preset_bar, 4'hF);
    check("rst_ready", Cmd_ready, 1);
    check("rst_done", Done, 0);
    check("rst_q", q_bank, 4'h0);
    @(posedge Clk); #1 Clear_bar = 1'b1;
    @(posedge Clk); #1;

    // LOAD A
    send(3'd1, 4'hA, 4'hA, 1, 1, 0);
    check("load_j", J, 4'hA);
    check("load_k", K, 4'h5);
    check("load_ready_low", Cmd_ready, 0);
    @(posedge Clk); #1;
    check("load_ready_back", Cmd_ready, 1);

    // PRESET mask 3 from A
    send(3'd3, 4'h3, 4'hB, 3, 1, 0);
    check("pre_arm", Preset_bar, 4'hF);
    @(posedge Clk); #1;
    check("pre_low", Preset_bar, 4'hC);
    check("pre_low_jk", {J, K}, 8'h00);
    @(posedge Clk); #1;
    check("pre_rel", Preset_bar, 4'hF);

    // COUNT 5 from E wraps through zero
    send(3'd1, 4'hE, 4'hE, 1, 1, 0);
    send(3'd4, 4'd5, 4'h3, 5, 1, 0);
    for (int s = 0; s < 5; s++) begin
      @(posedge Clk); #1;
      check("count_step_q", q_bank, cseq[s]);
    end
    send(3'd4, 4'd0, 4'h3, 1, 1, 0);

    // TOGGLE 6 with valid held, LOAD 0 follows at edge after Done
    send(3'd2, 4'h6, 4'h5, 1, 1, 1);
    t0 = cyc;
    Op = 3'd1; Arg = 4'h0;
    exp_q.push_back(4'h0); exp_c.push_back(t0 + 3);
    @(posedge Clk); #1;
    check("b2b_ready_after_done", Cmd_ready, 1);
    @(posedge Clk); #1;
    check("b2b_second_accept", Cmd_ready, 0);
    check("b2b_load_k", K, 4'hF);
    Cmd_valid = 1'b0;
    drain();

    // Reset two steps into COUNT 8: no Done for the aborted command
    send(3'd4, 4'd8, 4'h0, 8, 0, 0);
    @(posedge Clk); #1;
    @(negedge Clk); #2;
    check("abort_q_before", q_bank, 4'h2);
    Clear_bar = 1'b0; #1;
    check("abort_jk", {J, K}, 8'h00);
    check("abort_q", q_bank, 4'h0);
    check("abort_done", Done, 0);
    @(posedge Clk); #1 Clear_bar = 1'b1;
    @(posedge Clk); #1;
    check("abort_ready", Cmd_ready, 1);

    // Normal operation after abort, then an invalid opcode holds Q
    send(3'd1, 4'h9, 4'h9, 1, 1, 0);
    send(3'd7, 4'hF, 4'h9, 1, 1, 0);
    check("invalid_jk", {J, K}, 8'h00);
    drain();
    repeat (3) @(posedge Clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
